// File: rtl/alu_seq_exec.sv
// alu_seq_exec: handshaked 32-bit ALU. Shift ops iterate one bit per cycle
// through a counter; all other ops finish on the accept edge.
module alu_seq_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      alu_control_op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_op_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_XOR = 4'b0011, OP_SLL = 4'b0100, OP_SRL = 4'b0101,
                         OP_SUB = 4'b0110, OP_SRA = 4'b0111, OP_SLT = 4'b1000;
  state_e          state_q;
  logic [3:0]      op_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] sh_q, res_q, alu_d, sh_d;
  logic            zero_q, ill_q, is_shift, is_ill;
  always_comb begin
    is_shift = alu_control_op_i inside {OP_SLL, OP_SRL, OP_SRA};
    is_ill   = alu_control_op_i > OP_SLT;
    case (alu_control_op_i)
      OP_AND:  alu_d = a_i & b_i;
      OP_OR:   alu_d = a_i | b_i;
      OP_ADD:  alu_d = a_i + b_i;
      OP_XOR:  alu_d = a_i ^ b_i;
      OP_SUB:  alu_d = a_i - b_i;
      OP_SLT:  alu_d = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      default: alu_d = '0;
    endcase
    // Arithmetic shift re-copies the MSB each step, so it always stays the captured bit 31.
    sh_d = op_q == OP_SLL ? {sh_q[XLEN-2:0], 1'b0} :
           op_q == OP_SRL ? {1'b0, sh_q[XLEN-1:1]} : {sh_q[XLEN-1], sh_q[XLEN-1:1]};
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (valid_i) begin
          op_q  <= alu_control_op_i;
          ill_q <= is_ill;
          if (is_shift) begin
            sh_q  <= a_i;
            cnt_q <= b_i[4:0];
            if (b_i[4:0] == 5'd0) begin
              res_q   <= a_i;
              zero_q  <= a_i == '0;
              state_q <= DONE;
            end else begin
              state_q <= SHIFT;
            end
          end else begin
            res_q   <= alu_d;
            zero_q  <= alu_d == '0;
            state_q <= DONE;
          end
        end
        SHIFT: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            res_q   <= sh_d;
            zero_q  <= sh_d == '0;
            state_q <= DONE;
          end
        end
        DONE: if (ready_i) begin
          res_q   <= '0;
          zero_q  <= 1'b0;
          ill_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ready_o      = state_q == IDLE;
  assign valid_o      = state_q == DONE;
  assign result_o     = res_q;
  assign zero_o       = zero_q;
  assign illegal_op_o = ill_q;
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: scoreboard bench for alu_seq_exec
module tb_alu_seq_exec;
  logic        clk = 0, rst_n = 0, valid = 0, ready_in = 0;
  logic [3:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic        ready_out, valid_out, zero, ill;
  logic [31:0] res;
  int total = 0, bad = 0;
  typedef struct packed {logic [31:0] r; logic z; logic il; logic [6:0] lat;} exp_t;
  exp_t sb[$];

  alu_seq_exec #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready_out),
    .alu_control_op_i(op), .a_i(a), .b_i(b), .valid_o(valid_out),
    .ready_i(ready_in), .result_o(res), .zero_o(zero), .illegal_op_o(ill)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [4:0] s;
    s = y[4:0];
    case (o)
      4'd0: e.r = x & y;
      4'd1: e.r = x | y;
      4'd2: e.r = x + y;
      4'd3: e.r = x ^ y;
      4'd4: e.r = x << s;
      4'd5: e.r = x >> s;
      4'd6: e.r = x - y;
      4'd7: e.r = $signed(x) >>> s;
      4'd8: e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: e.r = 32'd0;
    endcase
    e.z   = e.r == 32'd0;
    e.il  = o > 4'd8;
    e.lat = (o == 4'd4 || o == 4'd5 || o == 4'd7) ? 7'(s) + 7'd1 : 7'd1;
    return e;
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (!ready_out && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (ready_out !== 1'b1) begin bad++; $display("FAIL accept_wait ready_o=%b want=1", ready_out); end
    sb.push_back(model(o, x, y));
    op = o; a = x; b = y; valid = 1;
    @(posedge clk); #1;
    valid = 0;
  endtask

  task automatic collect(input string name);
    exp_t e;
    int lat = 1;
    while (!valid_out && lat < 40) begin @(posedge clk); #1; lat++; end
    total++;
    if (valid_out !== 1'b1 || sb.size() == 0) begin
      bad++; $display("FAIL %s_valid valid_o=%b want=1 (queue=%0d)", name, valid_out, sb.size());
      return;
    end
    e = sb.pop_front();
    total++;
    if (lat !== int'(e.lat)) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, e.lat); end
    total++;
    if (res !== e.r) begin bad++; $display("FAIL %s_result got=%h want=%h", name, res, e.r); end
    total++;
    if ({zero, ill} !== {e.z, e.il}) begin bad++; $display("FAIL %s_flags zero/ill got=%b%b want=%b%b", name, zero, ill, e.z, e.il); end
  endtask

  task automatic release_check(input string name);
    ready_in = 1;
    @(posedge clk); #1;
    ready_in = 0;
    total++;
    if ({ready_out, valid_out, zero, ill, res} !== {4'b1000, 32'd0}) begin
      bad++; $display("FAIL %s_idle rdy/vld/z/ill/res got=%b%b%b%b/%h want=1000/0", name, ready_out, valid_out, zero, ill, res);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ready_out, valid_out, zero, ill, res} !== {4'b1000, 32'd0}) begin
      bad++; $display("FAIL reset rdy/vld/z/ill/res got=%b%b%b%b/%h want=1000/0", ready_out, valid_out, zero, ill, res);
    end
    rst_n = 1;
  endtask

  task automatic test_arith;
    issue(4'd2, 32'h7FFFFFFF, 32'd1);          collect("add_ovf"); release_check("add_ovf");
    issue(4'd6, 32'd5, 32'd5);                 collect("sub_zero"); release_check("sub_zero");
    issue(4'd8, 32'hFFFFFFFF, 32'd0);          collect("slt_neg"); release_check("slt_neg");
    issue(4'd8, 32'd3, 32'hFFFFFFFE);          collect("slt_pos"); release_check("slt_pos");
    issue(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF); collect("and"); release_check("and");
    issue(4'd1, 32'hA000_0001, 32'h0500_0010); collect("or"); release_check("or");
    issue(4'd3, 32'hDEAD_BEEF, 32'hFFFF_0000); collect("xor"); release_check("xor");
    issue(4'd6, 32'd0, 32'd1);                 collect("sub_wrap"); release_check("sub_wrap");
  endtask

  task automatic test_shift;
    issue(4'd7, 32'h80000000, 32'h3F);         collect("sra31"); release_check("sra31");
    issue(4'd5, 32'h80000000, 32'h3F);         collect("srl31"); release_check("srl31");
    issue(4'd4, 32'h1, 32'h0);                 collect("sll0"); release_check("sll0");
    issue(4'd4, 32'h8000_0003, 32'hFFFF_FFE5); collect("sll5_hi_b"); release_check("sll5_hi_b");
    issue(4'd7, 32'h4000_0000, 32'd3);         collect("sra_pos"); release_check("sra_pos");
    issue(4'd5, 32'h1, 32'd1);                 collect("srl_zero"); release_check("srl_zero");
  endtask

  task automatic test_illegal;
    issue(4'hF, 32'h1234, 32'h5678); collect("ill_f"); release_check("ill_f");
    issue(4'h9, 32'h0, 32'h0);       collect("ill_9"); release_check("ill_9");
  endtask

  task automatic test_backpressure;
    issue(4'd2, 32'd10, 32'd20);
    collect("bp");
    for (int i = 0; i < 5; i++) begin
      valid = 1; op = 4'd0; a = 32'hFFFF; b = 32'h1;
      @(posedge clk); #1;
      total++;
      if ({valid_out, ready_out, res} !== {2'b10, 32'd30}) begin
        bad++; $display("FAIL bp_hold%0d vld/rdy/res got=%b%b/%h want=10/1e", i, valid_out, ready_out, res);
      end
    end
    valid = 0;
    release_check("bp");
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL bp_not_captured valid_o=%b want=0", valid_out); end
  endtask

  task automatic test_early_ready;
    ready_in = 1;
    issue(4'd4, 32'd3, 32'd4);
    collect("early_rdy");
    @(posedge clk); #1;
    ready_in = 0;
    total++;
    if ({ready_out, valid_out} !== 2'b10) begin bad++; $display("FAIL early_rdy_idle rdy/vld got=%b%b want=10", ready_out, valid_out); end
  endtask

  task automatic test_reset_abort;
    bit seen = 0;
    issue(4'd4, 32'd1, 32'd10);
    repeat (3) @(posedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    sb.delete();
    total++;
    if ({ready_out, valid_out, zero, ill, res} !== {4'b1000, 32'd0}) begin
      bad++; $display("FAIL abort_idle rdy/vld/z/ill/res got=%b%b%b%b/%h want=1000/0", ready_out, valid_out, zero, ill, res);
    end
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; if (valid_out) seen = 1; end
    total++;
    if (seen) begin bad++; $display("FAIL abort_no_result valid_o seen=1 want=0"); end
    issue(4'd2, 32'd2, 32'd3); collect("abort_add"); release_check("abort_add");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 12; i++) begin
      issue(4'($urandom_range(0, 15)), $urandom, $urandom);
      collect("rand");
      release_check("rand");
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_shift;
    test_illegal;
    test_backpressure;
    test_early_ready;
    test_reset_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
